pe_os_mac: RTL and testbench



---
 rtl/pe_pkg.sv | 44 ++++
 rtl/pe_os_mac_sat_mac.sv | 38 +++
 rtl/pe_os_mac.sv | 144 ++++++++++++++
 tb/tb_pe_os_mac.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared types and helpers for the output-stationary MAC processing element.
package pe_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam int unsigned SA_W = 65;

  function automatic int unsigned acc_w_def(
    input int unsigned bw
  );
    return 2 * bw + 8;
  endfunction

  // Operands arrive extended to SA_W bits; w must stay below SA_W-1.
  // Returns {sat, clamped sum} with the sum in the low w bits.
  function automatic logic [SA_W-1:0] sat_add(
    input logic signed [SA_W-1:0] a,
    input logic signed [SA_W-1:0] b,
    input int unsigned            w,
    input bit                     sgn
  );
    logic signed [SA_W-1:0] s;
    logic signed [SA_W-1:0] mx;
    logic signed [SA_W-1:0] mn;
    logic                   sat;
    s   = a + b;
    mx  = sgn ? (65'sd1 <<< (w - 1)) - 65'sd1
              : (65'sd1 <<< w) - 65'sd1;
    mn  = sgn ? -(65'sd1 <<< (w - 1)) : 65'sd0;
    sat = 1'b0;
    if (s > mx) begin
      s   = mx;
      sat = 1'b1;
    end else if (s < mn) begin
      s   = mn;
      sat = 1'b1;
    end
    return {sat, s[SA_W-2:0]};
  endfunction

endpackage

// File: rtl/pe_os_mac_sat_mac.sv
// Combinational multiply, extend and saturating accumulate.
module pe_sat_mac
  import pe_pkg::*;
#(
  parameter int unsigned BW     = 8,
  parameter int unsigned ACC_W  = 24,
  parameter bit          SIGNED = 1'b1
) (
  input  logic [BW-1:0]    act,
  input  logic [BW-1:0]    wgt,
  input  logic [ACC_W-1:0] acc,
  output logic [ACC_W-1:0] sum,
  output logic             sat
);

  logic signed [2*BW-1:0] ax;
  logic signed [2*BW-1:0] wx;
  logic signed [2*BW-1:0] prod;
  logic signed [SA_W-1:0] p_ext;
  logic signed [SA_W-1:0] a_ext;
  logic [SA_W-1:0]        r;
  logic                   unused_hi;

  always_comb begin
    ax = {{BW{SIGNED & act[BW-1]}}, act};
    wx = {{BW{SIGNED & wgt[BW-1]}}, wgt};
    // Low 2*BW bits of the extended product are exact.
    prod  = ax * wx;
    p_ext = {{(SA_W-2*BW){SIGNED & prod[2*BW-1]}}, prod};
    a_ext = {{(SA_W-ACC_W){SIGNED & acc[ACC_W-1]}}, acc};
    r     = sat_add(p_ext, a_ext, ACC_W, SIGNED);
  end

  assign sum       = r[ACC_W-1:0];
  assign sat       = r[SA_W-1];
  assign unused_hi = ^r[SA_W-2:ACC_W];

endmodule

// File: rtl/pe_os_mac.sv
// Output-stationary MAC PE: operand forwarding, saturating
// accumulate and a one-deep result register.
module pe_os_mac
  import pe_pkg::*;
#(
  parameter int unsigned BW     = 8,
  parameter int unsigned ACC_W  = acc_w_def(BW),
  parameter bit          SIGNED = 1'b1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_valid,
  input  logic             i_last,
  input  logic [BW-1:0]    i_activation,
  input  logic [BW-1:0]    i_weight,
  output logic             o_ready,
  output logic [BW-1:0]    o_activation,
  output logic [BW-1:0]    o_weight,
  output logic             o_fwd_valid,
  output logic [ACC_W-1:0] o_result,
  output logic [CNT_W-1:0] o_result_count,
  output logic             o_result_sat,
  output logic             o_result_valid,
  input  logic             i_result_ready
);

  state_t           state;
  state_t           state_nxt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             sat_r;
  logic             sat_f;
  logic             sat_inc;
  logic             beat;
  logic             drain;
  logic             upd;
  logic             load;
  logic             load_acc;
  logic             clr;

  pe_sat_mac #(
    .BW    (BW),
    .ACC_W (ACC_W),
    .SIGNED(SIGNED)
  ) u_mac (
    .act(i_activation),
    .wgt(i_weight),
    .acc(acc),
    .sum(sum),
    .sat(sat_f)
  );

  assign o_ready = (state == ACCUM);
  assign beat    = i_valid && o_ready;
  assign drain   = o_result_valid && i_result_ready;
  assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;
  assign sat_inc = sat_r | sat_f;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state <= ACCUM;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    upd       = 1'b0;
    load      = 1'b0;
    load_acc  = 1'b0;
    clr       = 1'b0;
    unique case (state)
      ACCUM: begin
        if (beat) begin
          if (!i_last) begin
            upd = 1'b1;
          end else if (!o_result_valid || drain) begin
            load = 1'b1;
            clr  = 1'b1;
          end else begin
            upd       = 1'b1;
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (drain) begin
          load      = 1'b1;
          load_acc  = 1'b1;
          clr       = 1'b1;
          state_nxt = ACCUM;
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      acc            <= '0;
      cnt            <= '0;
      sat_r          <= 1'b0;
      o_result       <= '0;
      o_result_count <= '0;
      o_result_sat   <= 1'b0;
      o_result_valid <= 1'b0;
    end else begin
      if (clr) begin
        acc   <= '0;
        cnt   <= '0;
        sat_r <= 1'b0;
      end else if (upd) begin
        acc   <= sum;
        cnt   <= cnt_inc;
        sat_r <= sat_inc;
      end
      // A held result comes from the accumulator, a fresh one from the adder.
      if (load) begin
        o_result       <= load_acc ? acc : sum;
        o_result_count <= load_acc ? cnt : cnt_inc;
        o_result_sat   <= load_acc ? sat_r : sat_inc;
        o_result_valid <= 1'b1;
      end else if (drain) begin
        o_result_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_activation <= '0;
      o_weight     <= '0;
      o_fwd_valid  <= 1'b0;
    end else begin
      o_fwd_valid <= beat;
      if (beat) begin
        o_activation <= i_activation;
        o_weight     <= i_weight;
      end
    end
  end

endmodule

// File: tb/tb_pe_os_mac.sv
// Bench for pe_os_mac: a signed 24-bit PE and an unsigned 16-bit PE
// checked against an arithmetic model plus directed literals.
module tb_pe_os_mac;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [1:0]       vld;
  logic [1:0]       lst;
  logic [1:0]       rr;
  logic [1:0][7:0]  act;
  logic [1:0][7:0]  wgt;
  logic [1:0]       rdy;
  logic [1:0]       fv;
  logic [1:0]       rv;
  logic [1:0]       rsat;
  logic [1:0][7:0]  fa;
  logic [1:0][7:0]  fw;
  logic [1:0][15:0] rcnt;
  logic [23:0]      res0;
  logic [15:0]      res1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pe_os_mac #(
    .BW(8), .ACC_W(24), .SIGNED(1'b1), .CNT_W(16)
  ) dut0 (
    .i_clock(clk), .i_reset(rst),
    .i_valid(vld[0]), .i_last(lst[0]),
    .i_activation(act[0]), .i_weight(wgt[0]),
    .o_ready(rdy[0]),
    .o_activation(fa[0]), .o_weight(fw[0]),
    .o_fwd_valid(fv[0]),
    .o_result(res0), .o_result_count(rcnt[0]),
    .o_result_sat(rsat[0]), .o_result_valid(rv[0]),
    .i_result_ready(rr[0])
  );

  pe_os_mac #(
    .BW(8), .ACC_W(16), .SIGNED(1'b0), .CNT_W(16)
  ) dut1 (
    .i_clock(clk), .i_reset(rst),
    .i_valid(vld[1]), .i_last(lst[1]),
    .i_activation(act[1]), .i_weight(wgt[1]),
    .o_ready(rdy[1]),
    .o_activation(fa[1]), .o_weight(fw[1]),
    .o_fwd_valid(fv[1]),
    .o_result(res1), .o_result_count(rcnt[1]),
    .o_result_sat(rsat[1]), .o_result_valid(rv[1]),
    .i_result_ready(rr[1])
  );

  // Model state: plain integers, one slot per PE.
  longint    m_acc[2];
  longint    m_cnt[2];
  longint    m_res[2];
  longint    m_rcnt[2];
  longint    m_beats[2];
  bit        m_sat[2];
  bit        m_rsat[2];
  bit        m_rv[2];
  bit        m_hold[2];
  bit        m_fv[2];
  logic [7:0] m_fa[2];
  logic [7:0] m_fw[2];

  function automatic int aw(int k);
    return (k == 0) ? 24 : 16;
  endfunction

  function automatic bit sg(int k);
    return (k == 0);
  endfunction

  task automatic mreset(int k);
    m_acc[k]  = 0; m_cnt[k]  = 0; m_sat[k]  = 0;
    m_res[k]  = 0; m_rcnt[k] = 0; m_rsat[k] = 0;
    m_rv[k]   = 0; m_hold[k] = 0; m_fv[k]   = 0;
    m_fa[k]   = '0; m_fw[k]  = '0;
  endtask

  task automatic publish(int k);
    m_res[k]  = m_acc[k];
    m_rcnt[k] = m_cnt[k];
    m_rsat[k] = m_sat[k];
    m_acc[k]  = 0;
    m_cnt[k]  = 0;
    m_sat[k]  = 0;
  endtask

  task automatic mstep(int k);
    longint p, s, mx, mn, one;
    bit drain, loaded;
    one    = 1;
    drain  = m_rv[k] && rr[k];
    loaded = 0;
    m_fv[k] = 0;
    if (!m_hold[k]) begin
      if (vld[k]) begin
        m_fv[k] = 1;
        m_fa[k] = act[k];
        m_fw[k] = wgt[k];
        m_beats[k]++;
        if (sg(k))
          p = longint'($signed(act[k])) * longint'($signed(wgt[k]));
        else
          p = longint'(act[k]) * longint'(wgt[k]);
        mx = sg(k) ? (one << (aw(k) - 1)) - 1 : (one << aw(k)) - 1;
        mn = sg(k) ? -(one << (aw(k) - 1)) : 0;
        s  = m_acc[k] + p;
        if (s > mx) begin
          s = mx; m_sat[k] = 1;
        end else if (s < mn) begin
          s = mn; m_sat[k] = 1;
        end
        m_acc[k] = s;
        m_cnt[k] = (m_cnt[k] == 65535) ? 65535 : m_cnt[k] + 1;
        if (lst[k]) begin
          if (!m_rv[k] || drain) begin
            publish(k);
            loaded = 1;
          end else begin
            m_hold[k] = 1;
          end
        end
      end
    end else if (drain) begin
      publish(k);
      m_hold[k] = 0;
      loaded    = 1;
    end
    if (loaded)     m_rv[k] = 1;
    else if (drain) m_rv[k] = 0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mreset(0);
      mreset(1);
    end else begin
      mstep(0);
      mstep(1);
    end
  end

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic cmp(int k);
    logic [63:0] got;
    logic [63:0] mask;
    got  = (k == 0) ? {40'b0, res0} : {48'b0, res1};
    mask = (64'd1 << aw(k)) - 64'd1;
    chk($sformatf("m%0d.ready", k), 64'(rdy[k]), 64'(!m_hold[k]));
    chk($sformatf("m%0d.fwd_valid", k), 64'(fv[k]), 64'(m_fv[k]));
    chk($sformatf("m%0d.fwd_act", k), 64'(fa[k]), 64'(m_fa[k]));
    chk($sformatf("m%0d.fwd_wgt", k), 64'(fw[k]), 64'(m_fw[k]));
    chk($sformatf("m%0d.res_valid", k), 64'(rv[k]), 64'(m_rv[k]));
    if (m_rv[k]) begin
      chk($sformatf("m%0d.result", k), got, 64'(m_res[k]) & mask);
      chk($sformatf("m%0d.count", k), 64'(rcnt[k]), 64'(m_rcnt[k]));
      chk($sformatf("m%0d.sat", k), 64'(rsat[k]), 64'(m_rsat[k]));
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      cmp(0);
      cmp(1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(int k, bit v, bit l, logic [7:0] a, logic [7:0] w);
    vld[k] = v;
    lst[k] = l;
    act[k] = a;
    wgt[k] = w;
  endtask

  initial begin
    vld = '0; lst = '0; rr = '0; act = '0; wgt = '0;
    m_beats[0] = 0;
    m_beats[1] = 0;
    #1 rst = 1'b1;
    tick();
    tick();
    chk("rst.ready", 64'(rdy[0]), 64'd1);
    chk("rst.res_valid", 64'(rv[0]), 64'd0);
    chk("rst.fwd_valid", 64'(fv[0]), 64'd0);
    chk("rst.result", 64'(res0), 64'd0);
    rst = 1'b0;
    tick();

    // Signed dot product 3*4 - 2*5 - 7 = -5
    rr[0] = 1'b1;
    drv(0, 1, 0, 8'd3, 8'd4);  tick();
    chk("t1.fwd_valid", 64'(fv[0]), 64'd1);
    chk("t1.fwd_act", 64'(fa[0]), 64'd3);
    chk("t1.fwd_wgt", 64'(fw[0]), 64'd4);
    drv(0, 1, 0, 8'hFE, 8'd5); tick();
    chk("t1.no_res", 64'(rv[0]), 64'd0);
    chk("t1.fwd_act2", 64'(fa[0]), 64'hFE);
    drv(0, 1, 1, 8'd7, 8'hFF); tick();
    chk("t1.res_valid", 64'(rv[0]), 64'd1);
    chk("t1.result", 64'(res0), 64'hFFFFFB);
    chk("t1.count", 64'(rcnt[0]), 64'd3);
    chk("t1.sat", 64'(rsat[0]), 64'd0);
    chk("t1.fwd_wgt3", 64'(fw[0]), 64'hFF);
    drv(0, 0, 0, 8'h5A, 8'hA5); tick();
    chk("t1.fwd_idle", 64'(fv[0]), 64'd0);
    chk("t1.fwd_hold", 64'(fa[0]), 64'd7);
    chk("t1.drained", 64'(rv[0]), 64'd0);

    // Unsigned 16-bit: 2*65025 clamps to 65535
    rr[1] = 1'b1;
    drv(1, 1, 0, 8'd255, 8'd255); tick();
    drv(1, 1, 1, 8'd255, 8'd255); tick();
    chk("t2.result", 64'(res1), 64'd65535);
    chk("t2.sat", 64'(rsat[1]), 64'd1);
    chk("t2.count", 64'(rcnt[1]), 64'd2);
    drv(1, 1, 1, 8'd1, 8'd1); tick();
    chk("t2.result2", 64'(res1), 64'd1);
    chk("t2.sat2", 64'(rsat[1]), 64'd0);
    chk("t2.count2", 64'(rcnt[1]), 64'd1);
    drv(1, 0, 0, 8'd0, 8'd0); tick();

    // Back-pressure: second result waits in HOLD
    rr[0] = 1'b0;
    drv(0, 1, 1, 8'd2, 8'd3); tick();
    chk("t3.res_valid", 64'(rv[0]), 64'd1);
    chk("t3.result", 64'(res0), 64'd6);
    chk("t3.ready", 64'(rdy[0]), 64'd1);
    drv(0, 1, 1, 8'd4, 8'd5); tick();
    chk("t3.hold_ready", 64'(rdy[0]), 64'd0);
    chk("t3.result_kept", 64'(res0), 64'd6);
    drv(0, 0, 0, 8'd0, 8'd0); tick();
    chk("t3.still_hold", 64'(rdy[0]), 64'd0);
    rr[0] = 1'b1; tick(); rr[0] = 1'b0;
    chk("t3.result20", 64'(res0), 64'd20);
    chk("t3.valid20", 64'(rv[0]), 64'd1);
    chk("t3.ready_back", 64'(rdy[0]), 64'd1);
    tick();
    chk("t3.held20", 64'(res0), 64'd20);

    // Drain and load on the same edge
    rr[0] = 1'b1;
    drv(0, 1, 1, 8'd1, 8'd9); tick();
    chk("t4.valid", 64'(rv[0]), 64'd1);
    chk("t4.result", 64'(res0), 64'd9);
    chk("t4.count", 64'(rcnt[0]), 64'd1);
    drv(0, 0, 0, 8'd0, 8'd0); tick();
    chk("t4.drained", 64'(rv[0]), 64'd0);

    // Reset mid dot product
    drv(0, 1, 0, 8'd5, 8'd5); tick();
    drv(0, 1, 0, 8'd6, 8'd6); tick();
    drv(0, 0, 0, 8'd0, 8'd0);
    rst = 1'b1;
    #1;
    chk("t5.fwd_valid", 64'(fv[0]), 64'd0);
    chk("t5.fwd_act", 64'(fa[0]), 64'd0);
    chk("t5.res_valid", 64'(rv[0]), 64'd0);
    chk("t5.result", 64'(res0), 64'd0);
    chk("t5.ready", 64'(rdy[0]), 64'd1);
    tick();
    rst = 1'b0;
    drv(0, 1, 1, 8'd1, 8'd1); tick();
    chk("t5.result1", 64'(res0), 64'd1);
    chk("t5.count1", 64'(rcnt[0]), 64'd1);
    chk("t5.valid1", 64'(rv[0]), 64'd1);
    drv(0, 0, 0, 8'd0, 8'd0); tick();

    // Random traffic with gaps and back-pressure
    m_beats[0] = 0;
    m_beats[1] = 0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (m_beats[0] >= 1000 && m_beats[1] >= 1000) break;
      for (int k = 0; k < 2; k++) begin
        drv(k, $urandom_range(0, 2) != 0, $urandom_range(0, 5) == 0,
            8'($urandom), 8'($urandom));
        rr[k] = $urandom_range(0, 3) != 0;
      end
      tick();
    end
    chk("rand.beats0", 64'(m_beats[0] >= 1000), 64'd1);
    chk("rand.beats1", 64'(m_beats[1] >= 1000), 64'd1);
    drv(0, 0, 0, 8'd0, 8'd0);
    drv(1, 0, 0, 8'd0, 8'd0);
    rr = 2'b11;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
